// File: rtl/io_port_pkg.sv
// Shared types and helpers for the CPU-side I/O port bank.
package io_port_pkg;

  typedef enum logic {
    IO_DATA   = 1'b0,
    IO_STATUS = 1'b1
  } io_mode_t;

  function automatic int groups(input int ch, input int w);
    return (ch + w - 1) / w;
  endfunction

endpackage

// File: rtl/port_sync.sv
// W-bit multi-flop synchroniser for one asynchronous input channel.
module port_sync #(
  parameter int W           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [SYNC_STAGES-1:0][W-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= '0;
    else      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
  end

  assign q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/io_port_bank.sv
// CPU-side I/O port bank: synchronised inputs with sticky change flags,
// strobed output latches, status/mask groups and a maskable interrupt.
module io_port_bank
  import io_port_pkg::*;
#(
  parameter int CHANNELS    = 8,
  parameter int W           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SEL_W       = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [W-1:0]          din,
  output logic [W-1:0]          dout,
  input  logic [CHANNELS*W-1:0] port_in,
  output logic [CHANNELS*W-1:0] port_out,
  output logic [CHANNELS-1:0]   port_stb,
  output logic                  irq
);

  localparam int GROUPS = groups(CHANNELS, W);
  localparam int PADW   = GROUPS * W;

  logic [CHANNELS-1:0][W-1:0] w_s;
  logic [CHANNELS-1:0][W-1:0] r_prev;
  logic [CHANNELS-1:0][W-1:0] r_out;
  logic [CHANNELS-1:0][W-1:0] w_out_nxt;
  logic [CHANNELS-1:0]        r_chg;
  logic [CHANNELS-1:0]        w_chg_nxt;
  logic [CHANNELS-1:0]        r_en;
  logic [CHANNELS-1:0]        r_stb;
  logic [CHANNELS-1:0]        w_stb_nxt;
  logic [PADW-1:0]            w_chg_pad;
  logic [PADW-1:0]            w_en_pad;
  logic [PADW-1:0]            w_win;
  logic [PADW-1:0]            w_ins;
  logic [W-1:0]               w_rdata;
  logic [W-1:0]               w_stat;
  logic [W-1:0]               r_dout;
  logic                       r_irq;
  io_mode_t                   w_mode;
  logic                       w_rd_data;
  logic                       w_wr_data;
  logic                       w_wr_mask;
  int                         w_sh;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_sync
    port_sync #(
      .W          (W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (port_in[k*W +: W]),
      .q  (w_s[k])
    );
  end

  always_comb begin
    w_mode    = io_mode_t'(mode);
    w_rd_data = rd && (w_mode == IO_DATA);
    w_wr_data = wr && (w_mode == IO_DATA);
    w_wr_mask = wr && (w_mode == IO_STATUS);
    w_sh      = int'(sel) * W;
    w_rdata   = '0;
    w_chg_nxt = r_chg;
    w_out_nxt = r_out;
    w_stb_nxt = '0;
    // No channel matches an out-of-range select, so it reads 0 and does nothing
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k)) begin
        if (w_rd_data) begin
          w_rdata      = w_s[k];
          w_chg_nxt[k] = 1'b0;
        end
        if (w_wr_data) begin
          w_out_nxt[k] = din;
          w_stb_nxt[k] = 1'b1;
        end
      end
    end
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_s[k] != r_prev[k]) w_chg_nxt[k] = 1'b1;
    end
  end

  // Status groups are padded to whole words; shifting past the end yields 0
  always_comb begin
    w_chg_pad = PADW'(r_chg);
    w_en_pad  = PADW'(r_en);
    w_stat    = W'(w_chg_pad >> w_sh);
    w_win     = PADW'({W{1'b1}}) << w_sh;
    w_ins     = PADW'(din) << w_sh;
    if (w_wr_mask) w_en_pad = (w_en_pad & ~w_win) | w_ins;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev <= '0;
      r_chg  <= '0;
      r_en   <= '0;
      r_out  <= '0;
      r_stb  <= '0;
      r_dout <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_prev <= w_s;
      r_chg  <= w_chg_nxt;
      r_en   <= w_en_pad[CHANNELS-1:0];
      r_out  <= w_out_nxt;
      r_stb  <= w_stb_nxt;
      r_irq  <= |(r_chg & r_en);
      if (rd) r_dout <= (w_mode == IO_STATUS) ? w_stat : w_rdata;
    end
  end

  assign dout     = r_dout;
  assign port_out = r_out;
  assign port_stb = r_stb;
  assign irq      = r_irq;

endmodule

// File: tb/tb_io_port_bank.sv
// Scoreboard bench for io_port_bank (8 channels x 4 bits, 2-stage sync).
module tb_io_port_bank;
  import io_port_pkg::*;

  localparam int CH = 8;
  localparam int W  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    sel = '0;
  logic          mode = 1'b0;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  dout;
  logic [CH*W-1:0] port_in = '0;
  logic [CH*W-1:0] port_out;
  logic [CH-1:0] port_stb;
  logic          irq;

  int n_cmp = 0;
  int n_bad = 0;

  string       q_tag[$];
  logic [31:0] q_val[$];

  io_port_bank #(
    .CHANNELS   (CH),
    .W          (W),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .mode    (mode),
    .rd      (rd),
    .wr      (wr),
    .din     (din),
    .dout    (dout),
    .port_in (port_in),
    .port_out(port_out),
    .port_stb(port_stb),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    q_tag.push_back(tag);
    q_val.push_back(val);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    if (q_val.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else chk(q_tag.pop_front(), obs, q_val.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_op(input logic m, input logic [2:0] s,
                       input logic [3:0] exp, input string tag);
    rd = 1'b1; mode = m; sel = s;
    push(tag, 32'(exp));
    tick();
    rd = 1'b0;
    pop_chk(32'(dout));
  endtask

  task automatic wr_op(input logic m, input logic [2:0] s,
                       input logic [3:0] d);
    wr = 1'b1; mode = m; sel = s; din = d;
    tick();
    wr = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    push("rst_dout", 0);   pop_chk(32'(dout));
    push("rst_out", 0);    pop_chk(port_out);
    push("rst_stb", 0);    pop_chk(32'(port_stb));
    push("rst_irq", 0);    pop_chk(32'(irq));

    // make state nonzero, then async reset mid-cycle
    port_in = 32'hFFFF_FFFF;
    tick();
    rst = 1'b1;
    repeat (4) tick();
    wr_op(IO_STATUS, 3'd0, 4'hF);
    tick();
    push("pre_irq", 1);    pop_chk(32'(irq));
    rd_op(IO_STATUS, 3'd0, 4'hF, "pre_stat0");
    wr_op(IO_DATA, 3'd0, 4'h5);
    push("pre_out0", 32'h5); pop_chk(port_out);
    #3 rst = 1'b0;
    #1;
    push("arst_dout", 0);  pop_chk(32'(dout));
    push("arst_out", 0);   pop_chk(port_out);
    push("arst_stb", 0);   pop_chk(32'(port_stb));
    push("arst_irq", 0);   pop_chk(32'(irq));

    // flags rise SYNC_STAGES+1 edges after release (prev starts at 0)
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    tick();
    rd_op(IO_STATUS, 3'd0, 4'h0, "lat_early");
    rd_op(IO_STATUS, 3'd0, 4'hF, "lat_g0");
    rd_op(IO_STATUS, 3'd1, 4'hF, "lat_g1");
    rd_op(IO_STATUS, 3'd2, 4'h0, "stat_oob");

    // inputs to 0, then clear all flags via data reads
    port_in = '0;
    repeat (4) tick();
    for (int k = 0; k < CH; k++) rd_op(IO_DATA, 3'(k), 4'h0, "clr_rd");
    rd_op(IO_STATUS, 3'd0, 4'h0, "clr_g0");
    rd_op(IO_STATUS, 3'd1, 4'h0, "clr_g1");

    // write with strobe, then rewrite same value
    wr_op(IO_DATA, 3'd3, 4'hA);
    push("wr_out", 32'h0000_A000); pop_chk(port_out);
    push("wr_stb", 32'h08);        pop_chk(32'(port_stb));
    tick();
    push("wr_stb_off", 0);         pop_chk(32'(port_stb));
    push("wr_hold", 32'h0000_A000); pop_chk(port_out);
    wr_op(IO_DATA, 3'd3, 4'hA);
    push("rewr_stb", 32'h08);      pop_chk(32'(port_stb));

    // change on ch1 then data read clears it
    port_in[7:4] = 4'h5;
    tick();
    tick();
    rd_op(IO_STATUS, 3'd0, 4'h0, "chg_early");
    rd_op(IO_STATUS, 3'd0, 4'b0010, "chg_set");
    rd_op(IO_DATA, 3'd1, 4'h5, "chg_rd");
    rd_op(IO_STATUS, 3'd0, 4'h0, "chg_clr");

    // set and clear on the same edge: set wins
    port_in[7:4] = 4'hA;
    tick();
    tick();
    rd_op(IO_DATA, 3'd1, 4'hA, "race_rd");
    rd_op(IO_STATUS, 3'd0, 4'b0010, "race_kept");
    rd_op(IO_DATA, 3'd1, 4'hA, "race_clr_rd");
    rd_op(IO_STATUS, 3'd0, 4'h0, "race_clr");

    // status/mask/irq on ch5; ch2 input prepared for rd+wr
    port_in[23:20] = 4'h3;
    port_in[11:8]  = 4'h6;
    repeat (4) tick();
    rd_op(IO_DATA, 3'd2, 4'h6, "ch2_clr");
    rd_op(IO_STATUS, 3'd1, 4'b0010, "g1_ch5");
    push("irq_masked", 0);  pop_chk(32'(irq));
    wr_op(IO_STATUS, 3'd2, 4'hF);
    tick();
    push("irq_oobmask", 0); pop_chk(32'(irq));
    wr_op(IO_STATUS, 3'd1, 4'b0010);
    tick();
    push("irq_on", 1);      pop_chk(32'(irq));
    rd_op(IO_DATA, 3'd5, 4'h3, "ch5_rd");
    push("irq_lag", 1);     pop_chk(32'(irq));
    tick();
    push("irq_off", 0);     pop_chk(32'(irq));

    // simultaneous read and write on ch2
    rd = 1'b1; wr = 1'b1; mode = IO_DATA; sel = 3'd2; din = 4'h7;
    push("rw_dout", 32'h6);
    tick();
    rd = 1'b0; wr = 1'b0;
    pop_chk(32'(dout));
    push("rw_out", 32'h0000_A700); pop_chk(port_out);
    push("rw_stb", 32'h04);        pop_chk(32'(port_stb));
    tick();
    push("rw_stb_off", 0);         pop_chk(32'(port_stb));

    chk("sb_drain", 32'(q_val.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
